gin_feeder: RTL and testbench
=============================

Name: gin_feeder

Overview:
- Upstream stage of the global input network (GIN).
- Takes a flat stream of operand words from the global buffer read port and stamps each word with a (row_tag, col_tag) pair from programmable tile dimensions.
- Presents {enable, row_tag, col_tag, value} to the GIN slave port under the GIN ready handshake.
- A small registered FIFO breaks the combinational path from GIN ready back to the buffer.

Parameters:
- ID_LEN, 5, width of col_tag (X-bus PE id space).
- ROW_LEN, 4, width of row_tag (Y-bus id space).
- VALUE_LEN, 32, payload width.
- FIFO_DEPTH, 2, output buffer entries; power of two, minimum 2.
- CNT_LEN, 9, width of sent_count; must satisfy CNT_LEN >= ROW_LEN+ID_LEN.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse; launches one tile when idle.
- num_rows  in  ROW_LEN  row tags per tile; sampled on an accepted start.
- num_cols  in  ID_LEN  column tags per row; sampled on an accepted start.
- busy  out  1  high from an accepted start until the done cycle, inclusive.
- done  out  1  one-cycle pulse after the last word is accepted by GIN.
- in_valid  in  1  buffer data valid.
- in_ready  out  1  feeder accepts in_data this cycle.
- in_data  in  VALUE_LEN  operand word.
- enable  out  1  GIN slave valid; connects to GIN enable.
- ready  in  1  GIN slave ready.
- row_tag  out  ROW_LEN  Y-bus tag of the head word.
- col_tag  out  ID_LEN  X-bus tag of the head word.
- value  out  VALUE_LEN  payload of the head word.
- sent_count  out  CNT_LEN  words accepted by GIN in the current or last tile.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM returns to IDLE.
  - FIFO is emptied and the tag counters are zeroed.
  - busy, done, in_ready, enable and sent_count are 0.
  - row_tag, col_tag and value are 0.
  - Reset asserted mid-tile discards in-flight words; no done pulse is issued.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE to RUN on start when both num_rows and num_cols are nonzero. Latch the dimensions, zero the tag counters, zero sent_count.
  - IDLE to DONE on start when either dimension is 0. No transfers occur; done fires the next cycle.
  - RUN to DRAIN in the cycle the last word (row = num_rows-1, col = num_cols-1) is pushed.
  - DRAIN to DONE in the cycle the FIFO becomes empty after a pop.
  - DONE to IDLE unconditionally. done = 1 only while in DONE.
  - start is ignored in every state except IDLE.
- Input side:
  - in_ready = (state == RUN) && FIFO not full.
  - in_ready is a registered-state function only; it never depends on ready.
  - A push occurs when in_valid && in_ready. The pushed entry is {current row counter, current col counter, in_data}.
- Tag order, applied on each push:
  - col_tag advances fastest.
  - When col = num_cols-1, col wraps to 0 and row increments.
  - Counters freeze after the last push.
- Output side:
  - enable = FIFO not empty. row_tag, col_tag and value show the FIFO head.
  - A pop occurs when enable && ready; sent_count increments on each pop.
  - While enable is high and ready is low, the head is held stable.
- Simultaneous push and pop in one cycle are both honoured; occupancy is unchanged.
- A full FIFO blocks the push even if a pop occurs in the same cycle (no pass-through).
- Latency: first word at the input is on enable 1 cycle after it is pushed. Throughput is 1 word/cycle with ready held high.
- Width rules: tag counters are exactly ROW_LEN/ID_LEN wide. num_cols = 2^ID_LEN-1 is the maximum; no wrap beyond it.

Decomposition:
- Shared package: GIN field widths (ID_LEN, ROW_LEN, VALUE_LEN) and the packed enable/tag/value ordering {enable, row, col, value}. Used by both the GIN and this feeder.
- One sub-module: gin_feeder_fifo, a synchronous FIFO with FIFO_DEPTH entries and width ROW_LEN+ID_LEN+VALUE_LEN. It has push/pop/full/empty and a registered head.
- The FSM and tag counters stay in gin_feeder.

Test Plan:
- Basic tile: num_rows=2, num_cols=3, in_valid and ready held high, data 0x10..0x15.
  - Required tags in order: (0,0)(0,1)(0,2)(1,0)(1,1)(1,2) with matching values.
  - done pulses once; sent_count=6.
- GIN backpressure: same tile, ready low for cycles 2-5 after start.
  - enable stays high with the head held at (0,1)/0x11.
  - in_ready drops once the FIFO holds 2 words; no loss or duplication; final sent_count=6.
- Empty dimensions: start with num_rows=0, num_cols=4.
  - done pulses on the next cycle; enable and in_ready never assert; sent_count=0.
- Max width: num_rows=1, num_cols=31.
  - col_tag runs 0..30 with no wrap to row 1; done after 31 pops.
- Start while busy: a second start mid-tile with num_cols=7 is ignored; the tile completes with the original dimensions.
- Async reset: rst low in the middle of a tile with 1 word in the FIFO.
  - All outputs go to 0 immediately; no done pulse.
  - A new start after release runs cleanly from tag (0,0).

Source files
------------

// File: rtl/gin_feeder_pkg.sv
// Field widths and port layout of the global input network, shared by the GIN and its feeder.
package gin_feeder_pkg;

    localparam int GIN_ID_LEN    = 5;
    localparam int GIN_ROW_LEN   = 4;
    localparam int GIN_VALUE_LEN = 32;

    // Order of the slave-port bundle: {enable, row, col, value}.
    typedef struct packed {
        logic                     enable;
        logic [GIN_ROW_LEN-1:0]   row;
        logic [GIN_ID_LEN-1:0]    col;
        logic [GIN_VALUE_LEN-1:0] value;
    } gin_word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/gin_feeder_fifo.sv
// Registered FIFO: a pushed entry is at the head one cycle later. Pushing into a full FIFO
// is ignored even when a pop happens in the same cycle; pop on empty is ignored.
module gin_feeder_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_dat,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head_dat,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;

endmodule

// File: rtl/gin_feeder.sv
// Stamps buffer words with (row, col) tags and feeds the GIN slave port; 1-cycle push-to-enable.
// in_ready depends only on registered state, so GIN ready never reaches the buffer combinationally.
module gin_feeder
    import gin_feeder_pkg::*;
#(
    parameter int ID_LEN     = GIN_ID_LEN,
    parameter int ROW_LEN    = GIN_ROW_LEN,
    parameter int VALUE_LEN  = GIN_VALUE_LEN,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_LEN    = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ROW_LEN-1:0]   num_rows,
    input  logic [ID_LEN-1:0]    num_cols,
    output logic                 busy,
    output logic                 done,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [VALUE_LEN-1:0] in_data,
    output logic                 enable,
    input  logic                 ready,
    output logic [ROW_LEN-1:0]   row_tag,
    output logic [ID_LEN-1:0]    col_tag,
    output logic [VALUE_LEN-1:0] value,
    output logic [CNT_LEN-1:0]   sent_count
);
    localparam int ENTRY_W = ROW_LEN + ID_LEN + VALUE_LEN;
    localparam int OCC_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ID_LEN-1:0]  COL_ONE = ID_LEN'(1);
    localparam logic [ROW_LEN-1:0] ROW_ONE = ROW_LEN'(1);
    localparam logic [OCC_W-1:0]   OCC_ONE = OCC_W'(1);

    feeder_state_t      r_state;
    feeder_state_t      w_state_nxt;
    logic [ROW_LEN-1:0] r_num_rows;
    logic [ID_LEN-1:0]  r_num_cols;
    logic [ROW_LEN-1:0] r_row;
    logic [ID_LEN-1:0]  r_col;
    logic [CNT_LEN-1:0] r_sent_count;

    logic               w_full;
    logic               w_empty;
    logic [OCC_W-1:0]   w_count;
    logic [ENTRY_W-1:0] w_head;
    logic               w_push;
    logic               w_pop;
    logic               w_last_col;
    logic               w_last_word;
    logic               w_dims_ok;
    logic               w_start_acc;

    assign in_ready    = (r_state == ST_RUN) && !w_full;
    assign w_push      = in_valid && in_ready;
    assign enable      = !w_empty;
    assign w_pop       = enable && ready;
    assign w_last_col  = (r_col == r_num_cols - COL_ONE);
    assign w_last_word = w_last_col && (r_row == r_num_rows - ROW_ONE);
    assign w_dims_ok   = (num_rows != '0) && (num_cols != '0);
    assign w_start_acc = (r_state == ST_IDLE) && start;

    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != ST_IDLE);
        done        = (r_state == ST_DONE);
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = w_dims_ok ? ST_RUN : ST_DONE;
            ST_RUN:   if (w_push && w_last_word) w_state_nxt = ST_DRAIN;
            // Nothing is pushed in DRAIN, so popping the sole entry empties the FIFO.
            ST_DRAIN: if (w_pop && (w_count == OCC_ONE)) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_num_rows   <= '0;
            r_num_cols   <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_sent_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_acc) begin
                r_row        <= '0;
                r_col        <= '0;
                r_sent_count <= '0;
                if (w_dims_ok) begin
                    r_num_rows <= num_rows;
                    r_num_cols <= num_cols;
                end
            end else begin
                if (w_pop) begin
                    r_sent_count <= r_sent_count + 1'b1;
                end
                // Counters hold on the final push so they never run past the tile.
                if (w_push && !w_last_word) begin
                    if (w_last_col) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
            end
        end
    end

    gin_feeder_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_dat ({r_row, r_col, in_data}),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

    assign {row_tag, col_tag, value} = w_head;
    assign sent_count = r_sent_count;

endmodule

// File: tb/tb_gin_feeder.sv
// Bench for gin_feeder: table of tiles, randomized tiles, and hand-written reset/backpressure sequences.
module tb_gin_feeder;
    localparam int ID_LEN     = 5;
    localparam int ROW_LEN    = 4;
    localparam int VALUE_LEN  = 32;
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_LEN    = 9;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic [ROW_LEN-1:0]   num_rows = '0;
    logic [ID_LEN-1:0]    num_cols = '0;
    logic                 busy;
    logic                 done;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [VALUE_LEN-1:0] in_data = '0;
    logic                 enable;
    logic                 ready = 1'b0;
    logic [ROW_LEN-1:0]   row_tag;
    logic [ID_LEN-1:0]    col_tag;
    logic [VALUE_LEN-1:0] value;
    logic [CNT_LEN-1:0]   sent_count;

    always #5 clk = ~clk;

    gin_feeder #(
        .ID_LEN(ID_LEN), .ROW_LEN(ROW_LEN), .VALUE_LEN(VALUE_LEN),
        .FIFO_DEPTH(FIFO_DEPTH), .CNT_LEN(CNT_LEN)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .num_cols(num_cols),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .enable(enable), .ready(ready), .row_tag(row_tag), .col_tag(col_tag), .value(value),
        .sent_count(sent_count)
    );

    int tests = 0;
    int fails = 0;
    logic [VALUE_LEN-1:0] src [0:511];

    typedef struct packed {
        int rows; int cols; int vpct; int rpct;
        int lo_from; int lo_to; int spur_at; int exp_words;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_enable"}, enable, 0);
        check({tag, "_sent"}, sent_count, 0);
        check({tag, "_head"}, {row_tag, col_tag, value}, 0);
    endtask

    // Reference: word k of a tile carries tag (k / cols, k % cols) and the k-th accepted input.
    // in_ready is high exactly when words remain and the FIFO has space; enable when it holds any.
    task automatic run_tile(input int rows, input int cols, input int vpct, input int rpct,
                            input int lo_from, input int lo_to, input int spur_at,
                            output int n_pops);
        int total, pushes, pops, occ, i, last_pop_cycle, budget;
        bit finished, held, push, pop, exp_done;
        longint held_head;
        total = rows * cols;
        pushes = 0; pops = 0; occ = 0; last_pop_cycle = 0;
        finished = 0; held = 0; held_head = 0;
        budget = 30 * total + 40;
        num_rows = ROW_LEN'(rows); num_cols = ID_LEN'(cols);
        start = 1; in_valid = 0; ready = 0;
        step();
        start = 0;
        i = 1;
        while (!finished && i < budget) begin
            check("enable", enable, occ > 0);
            check("in_ready", in_ready, (pushes < total) && (occ < FIFO_DEPTH));
            check("sent_count", sent_count, pops);
            check("busy", busy, 1);
            exp_done = (pops == total) && (i == last_pop_cycle + 1);
            check("done", done, exp_done);
            if (held) check("head_hold", {row_tag, col_tag, value}, held_head);
            if (enable && pops < total) begin
                check("row_tag", row_tag, pops / cols);
                check("col_tag", col_tag, pops % cols);
                check("value", value, src[pops]);
            end
            if (lo_to > 0 && i == lo_to) check("bp_pops_in_stall", pops, 1);
            if (done) begin
                finished = 1;
            end else begin
                in_valid = ($urandom_range(1, 100) <= vpct);
                in_data  = (pushes < total) ? src[pushes] : 32'hDEAD_BEEF;
                if (lo_to > 0 && i >= lo_from && i <= lo_to) ready = 0;
                else ready = ($urandom_range(1, 100) <= rpct);
                if (spur_at == i) begin
                    start = 1; num_cols = 7; num_rows = ROW_LEN'(rows + 1);
                end
                #1;
                push = in_valid && in_ready;
                pop  = enable && ready;
                if (pop) begin
                    if (pops >= total) check("extra_pop", 1, 0);
                    pops++;
                    if (pops == total) last_pop_cycle = i;
                end
                if (push) pushes++;
                occ = occ + int'(push) - int'(pop);
                held = enable && !ready;
                held_head = {row_tag, col_tag, value};
                step();
                start = 0;
                i++;
            end
        end
        if (!finished) check("done_timeout", 0, 1);
        in_valid = 0; ready = 0;
        step();
        check("busy_after", busy, 0);
        check("done_after", done, 0);
        check("sent_final", sent_count, total);
        n_pops = pops;
    endtask

    vec_t tbl [8];

    initial begin
        int n;
        int r, c;
        tbl = '{
            '{2, 3, 100, 100, 0, 0, 0, 6},     // basic tile
            '{2, 3, 100, 100, 3, 6, 0, 6},     // GIN stall after the first pop
            '{0, 4, 100, 100, 0, 0, 0, 0},     // empty rows
            '{1, 31, 100, 100, 0, 0, 0, 31},   // widest row
            '{2, 3, 100, 100, 0, 0, 3, 6},     // start while busy
            '{4, 5, 60, 50, 0, 0, 0, 20},
            '{3, 0, 100, 100, 0, 0, 0, 0},     // empty cols
            '{2, 31, 80, 90, 0, 0, 0, 62}
        };

        // Reset state, with inputs wiggling underneath.
        in_valid = 1; ready = 1; start = 1; num_rows = 2; num_cols = 3;
        #1;
        check_all_zero("reset");
        step();
        check_all_zero("reset_clk");
        in_valid = 0; ready = 0; start = 0;
        rst = 1;
        step();
        check_all_zero("idle");

        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < 512; k++) src[k] = VALUE_LEN'(32'h10 + k);
            run_tile(tbl[t].rows, tbl[t].cols, tbl[t].vpct, tbl[t].rpct,
                     tbl[t].lo_from, tbl[t].lo_to, tbl[t].spur_at, n);
            check("tile_words", n, tbl[t].exp_words);
        end

        for (int t = 0; t < 15; t++) begin
            r = $urandom_range(0, 6);
            c = $urandom_range(0, 31);
            for (int k = 0; k < 512; k++) src[k] = $urandom;
            run_tile(r, c, $urandom_range(30, 100), $urandom_range(30, 100), 0, 0, 0, n);
            check("rand_words", n, r * c);
        end

        // Asynchronous reset with one word held in the FIFO.
        num_rows = 2; num_cols = 3; start = 1;
        step();
        start = 0; in_valid = 1; in_data = 32'hAA; ready = 0;
        step();
        in_valid = 0;
        check("pre_reset_enable", enable, 1);
        check("pre_reset_value", value, 32'hAA);
        #2 rst = 0;
        #1;
        check_all_zero("async_rst");
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_no_done", done, 0);
            check("rst_no_busy", busy, 0);
        end
        #3 rst = 1;
        step();
        check_all_zero("post_rst");
        for (int k = 0; k < 512; k++) src[k] = VALUE_LEN'(32'h100 + k);
        run_tile(2, 3, 100, 100, 0, 0, 0, n);
        check("post_rst_words", n, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

endmodule
